// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and helpers for the RAM-backed programmable delay line.
package delay_line_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    RECONF = 2'd2
  } state_t;

  // Selects what the output register presents; changes only on an acceptance.
  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_BYPASS = 2'd1,
    SEL_RAM    = 2'd2
  } out_sel_t;

  localparam int unsigned DEFAULT_MAX_DELAY = 1024;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  localparam bit DEFAULT_DEPTH_IS_POW2 = is_pow2(DEFAULT_MAX_DELAY);

  function automatic int unsigned clamp_delay(input int unsigned cfg, input int unsigned max);
    return (cfg > max) ? max : cfg;
  endfunction

endpackage

// File: rtl/delay_line_ctrl_ram.sv
// Simple dual-port sample buffer: one write and one registered read per cycle,
// a read of the address being written returns the previous contents.
module sdp_ram_row
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = DEFAULT_MAX_DELAY,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Programmable delay line controller: circular-buffer pointers, fill/reconfig FSM
// and valid/ready flow control. DELAY_LINE_CTRL_ZERO_FILL_EN emits zeros while filling.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_DELAY  = DEFAULT_MAX_DELAY,
  parameter int unsigned ADDR_WIDTH = $clog2(MAX_DELAY),
  parameter int unsigned CNT_WIDTH  = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CNT_WIDTH-1:0]  cfg_delay,
  input  logic                  cfg_load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  filling
);

  if (!is_pow2(MAX_DELAY)) begin : g_depth_check
    $error("delay_line_ctrl: MAX_DELAY must be a power of two");
  end

`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  state_t                state_reg, state_next;
  out_sel_t              sel_reg, sel_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [CNT_WIDTH-1:0]  fill_cnt_reg, fill_cnt_next;
  logic [CNT_WIDTH-1:0]  delay_reg;
  logic                  started_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] byp_data_reg;
  logic                  accept;
  logic                  produce;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // started_reg keeps in_ready low until the first edge after reset release.
  assign in_ready  = started_reg && (state_reg != RECONF) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  // A delay of MAX_DELAY truncates to zero: reading the slot about to be overwritten.
  assign rd_addr   = wr_ptr_reg - delay_reg[ADDR_WIDTH-1:0];
  assign filling   = (state_reg != RUN);
  assign out_valid = out_valid_reg;

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    sel_next      = sel_reg;
    produce       = 1'b0;
    unique case (state_reg)
      FILL: begin
        if (accept) begin
          fill_cnt_next = fill_cnt_reg + 1'b1;
          sel_next      = SEL_ZERO;
          produce       = ZERO_FILL;
          if (fill_cnt_next >= delay_reg) state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          produce  = 1'b1;
          sel_next = (delay_reg == '0) ? SEL_BYPASS : SEL_RAM;
        end
      end
      RECONF: begin
        state_next = (delay_reg == '0) ? RUN : FILL;
      end
      default: state_next = FILL;
    endcase
    // A load wins over any transition; the coincident sample already used the old delay.
    if (cfg_load) begin
      state_next    = RECONF;
      fill_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= FILL;
      sel_reg       <= SEL_ZERO;
      wr_ptr_reg    <= '0;
      fill_cnt_reg  <= '0;
      delay_reg     <= '0;
      started_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      byp_data_reg  <= '0;
    end else begin
      started_reg  <= 1'b1;
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      if (cfg_load) delay_reg <= CNT_WIDTH'(clamp_delay(32'(cfg_delay), MAX_DELAY));
      if (accept) begin
        wr_ptr_reg   <= wr_ptr_reg + 1'b1;
        byp_data_reg <= in_data;
        sel_reg      <= sel_next;
      end
      if (accept)         out_valid_reg <= produce;
      else if (out_ready) out_valid_reg <= 1'b0;
    end
  end

  always_comb begin
    unique case (sel_reg)
      SEL_RAM:    out_data = ram_rd_data;
      SEL_BYPASS: out_data = byp_data_reg;
      default:    out_data = '0;
    endcase
  end

  sdp_ram_row #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (MAX_DELAY),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(wr_ptr_reg),
    .wr_data(in_data),
    .rd_en  (accept),
    .rd_addr(rd_addr),
    .rd_data(ram_rd_data)
  );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: reference model is a history of accepted samples.
module tb_delay_line_ctrl;

  localparam int DW   = 16;
  localparam int MAXD = 1024;
  localparam int CW   = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cfg_delay = '0;
  logic          cfg_load = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          filling;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hist[$];
  int  m_d = 0;
  int  m_since = 0;
  bit  m_reconf = 0;
  bit  m_post_reset = 1;

  delay_line_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_delay(cfg_delay),
    .cfg_load (cfg_load),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .filling  (filling)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: an output equals the sample accepted D acceptances earlier,
  // once D samples have been taken since the last load.
  task automatic model_accept(input logic [DW-1:0] d);
    if (m_since < m_d) begin
      m_since++;
`ifdef DELAY_LINE_CTRL_ZERO_FILL_EN
      exp_q.push_back('0);
`endif
    end else if (m_d == 0) begin
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(hist[hist.size() - m_d]);
    end
    hist.push_back(d);
  endtask

  // One clock: drive on the falling edge, check and update the model just before the rising edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit ld, input int cd, input bit ordy);
    bit exp_fill;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_delay = CW'(cd);
    out_ready = ordy;
    #4;
    exp_fill = m_reconf || m_post_reset || (m_since < m_d);
    chk("filling", 32'(filling), 32'(exp_fill));
    if (m_reconf) chk("reconf_in_ready", 32'(in_ready), 0);
    if (in_valid && in_ready) model_accept(d);
    if (ld) begin
      m_d          = (cd > MAXD) ? MAXD : cd;
      m_since      = 0;
      m_reconf     = 1;
      m_post_reset = 0;
    end else begin
      m_reconf = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_filling", 32'(filling), 1);
    chk("rst_out_data", 32'(out_data), 0);
    exp_q.delete();
    hist.delete();
    m_d = 0; m_since = 0; m_reconf = 0; m_post_reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #4 chk("rel_in_ready_low", 32'(in_ready), 0);
    @(negedge clk);
    #4 chk("rel_in_ready_high", 32'(in_ready), 1);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks hold stability.
  initial begin
    bit pend = 0;
    logic [DW-1:0] pend_data = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("hold_valid", 32'(out_valid), 1);
          chk("hold_data", 32'(out_data), 32'(pend_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
        pend      = out_valid && !out_ready;
        pend_data = out_data;
      end
    end
  end

  initial begin
    int pos;
    #2;
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_in_ready", 32'(in_ready), 0);
    chk("init_filling", 32'(filling), 1);
    chk("init_out_data", 32'(out_data), 0);
    do_reset();

    // D=4 with a continuous ramp
    step(0, 0, 1, 4, 1);
    for (int i = 1; i <= 20; i++) step(1, DW'(i), 0, 0, 1);

    // D=0 bypass with random flow control
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), 0, 0, $urandom_range(0, 3) != 0);

    // 2000 clamps to the maximum delay; stream across several pointer wraps
    step(0, 0, 1, 2000, 1);
    for (int i = 0; i < 2100; i++) step(1, DW'(i * 7 + 3), 0, 0, 1);

    // D=8 random traffic, then a 5-cycle backpressure hold
    step(0, 0, 1, 8, 1);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 4) != 0, DW'($urandom), 0, 0, $urandom_range(0, 4) != 0);
    step(1, DW'($urandom), 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, DW'($urandom), 0, 0, 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    step(1, DW'($urandom), 0, 0, 1);
    step(1, DW'($urandom), 0, 0, 1);
    // Reload 8->3 coincident with an accepted sample
    chk("coincide_in_ready", 32'(in_ready), 1);
    step(1, DW'(16'hA5A5), 1, 3, 1);
    for (int i = 0; i < 30; i++) step(1, DW'(100 + i), 0, 0, 1);

    // Random delays, back-to-back loads and random handshakes
    step(0, 0, 1, 5, 1);
    step(0, 0, 1, 6, 1);
    for (int i = 0; i < 1500; i++) begin
      bit ld = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, DW'($urandom), ld, $urandom_range(0, 20),
           $urandom_range(0, 3) != 0);
    end

    // Reset while an output is pending in RUN
    step(0, 0, 1, 2, 1);
    for (int i = 0; i < 6; i++) step(1, DW'(i + 50), 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("pre_reset_out_valid", 32'(out_valid), 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("post_reset_out_valid", 32'(out_valid), 0);
    step(0, 0, 1, 5, 1);
    for (int i = 0; i < 25; i++) step(1, DW'(300 + i), 0, 0, $urandom_range(0, 2) != 0);

    // Drain with a bounded wait
    pos = 0;
    while (exp_q.size() != 0 && pos < 20) begin
      step(0, 0, 0, 0, 1);
      pos++;
    end
    step(0, 0, 0, 0, 1);
    chk("drain_queue_empty", 32'(exp_q.size()), 0);
    chk("drain_out_valid", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
